battle_phase_ctrl: RTL
======================

Name: battle_phase_ctrl

Overview:
- Top-level turn sequencer for the battle screen; it initiates the handshake that the enemy-attack block answers.
- Drives the 4-bit phase code and turn number to the phase blocks.
- Consumes the enemy block's busy, finished and damage pulses, plus the player-attack completion pulse.
- Maintains player and enemy HP, and declares win or lose.

Parameters:
PLAYER_HP, 20, player HP loaded at game start (1..255)
ENEMY_HP, 30, enemy HP loaded at game start (1..255)
HIT_DMG, 4, player HP lost per damage_in pulse
NUM_TURNS, 16, turn_out wraps to 0 after NUM_TURNS-1 (2..16)
TIMEOUT_CYCLES, 32'd650000000, enemy-phase watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system/pixel clock
rst  in  1  reset, synchronous, active-high
start_in  in  1  debounced one-cycle start pulse
player_done_in  in  1  one-cycle pulse: player attack phase complete
player_dmg_in  in  8  damage to enemy; sampled with player_done_in
enemy_busy_in  in  1  enemy phase block busy
enemy_finished_in  in  1  one-cycle pulse: enemy phase complete
damage_in  in  1  one-cycle pulse: arrow hit player
state_out  out  4  phase code: IDLE=4'b1010, PLAYER=4'b0100, ENEMY=4'b1000, WIN=4'b0001, LOSE=4'b1111
turn_out  out  4  current turn index (selects the enemy pattern)
player_hp_out  out  8  current player HP
enemy_hp_out  out  8  current enemy HP
game_over_out  out  1  high in WIN or LOSE
win_out  out  1  high in WIN only
timeout_out  out  1  sticky watchdog flag (0 when the feature is absent)

Behaviour:
- Reset values: state_out=IDLE, turn_out=0, player_hp_out=PLAYER_HP, enemy_hp_out=ENEMY_HP, game_over_out=0, win_out=0, timeout_out=0. rst mid-phase aborts immediately and discards in-flight pulses.
- All outputs are registered; every transition takes effect on the clock edge after the triggering input.
- IDLE:
  - start_in -> PLAYER; reload both HPs, turn_out=0.
  - All other inputs are ignored.
- PLAYER:
  - On player_done_in: enemy_hp <= saturating(enemy_hp - player_dmg_in), floored at 0.
  - If the result is 0 -> WIN; else -> ENEMY.
  - damage_in and enemy_finished_in are ignored.
- ENEMY:
  - state_out is held at 4'b1000 for the whole phase, so the enemy block sees exactly one rising edge per phase.
  - Each damage_in: player_hp <= saturating(player_hp - HIT_DMG), floored at 0.
  - If the new HP is 0 -> LOSE immediately, even while enemy_busy_in=1; later finished/damage pulses are ignored.
  - enemy_finished_in -> PLAYER, with turn_out <= (turn_out==NUM_TURNS-1) ? 0 : turn_out+1.
  - Same-cycle damage_in and enemy_finished_in: apply damage first. If HP reaches 0 -> LOSE and turn is unchanged; else -> PLAYER with turn advanced and HP reduced.
  - enemy_finished_in while enemy_busy_in has never been seen high in this phase is still accepted; busy is informational only.
- WIN / LOSE:
  - game_over_out=1; win_out=1 only in WIN.
  - HP values are frozen.
  - start_in -> PLAYER with HPs reloaded and turn_out=0.
- start_in outside IDLE, WIN and LOSE is ignored.
- Arithmetic: HP subtraction is 9-bit, clamped at 0; never wraps.

Optional Feature:
- Macro: BATTLE_PHASE_TIMEOUT_EN.
- Enabled:
  - A 32-bit counter clears on entering ENEMY and increments every ENEMY cycle.
  - When it reaches TIMEOUT_CYCLES with no finish or LOSE, timeout_out <= 1 (sticky until rst) and state -> PLAYER with turn advanced, exactly as for a finish.
  - A finish on the same cycle as the limit takes priority; timeout_out stays 0.
- Disabled: no counter is built, timeout_out is tied 0, and ENEMY waits indefinitely.

Test Plan:
- Reset, then start_in -> next cycle state_out=4'b0100, player_hp_out=20, enemy_hp_out=30, turn_out=0.
- PLAYER: player_done_in with dmg=12 -> enemy_hp_out=18, state_out=4'b1000. Then enemy_finished_in -> state_out=4'b0100, turn_out=1.
- ENEMY: 5 damage_in pulses -> player_hp 20->0 on the 5th pulse, state_out=4'b1111, game_over_out=1. A later enemy_finished_in leaves the state unchanged.
- PLAYER with enemy_hp=18: dmg=200 -> enemy_hp_out=0 (no wrap), state_out=4'b0001, win_out=1. Then start_in -> HPs reloaded to 20/30, turn_out=0.
- ENEMY with player_hp=8: damage_in and enemy_finished_in in the same cycle -> player_hp_out=4, state_out=4'b0100, turn_out incremented. With turn_out=15, the next finish wraps turn_out to 0.
- BATTLE_PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=100: enter ENEMY, no finish -> at count 100 timeout_out=1 and state_out=4'b0100. Without the macro: still ENEMY after 1000 cycles, timeout_out=0.

Source files
------------

// File: rtl/battle_phase_ctrl.sv
// Battle-screen turn sequencer: phase code, turn index, HP bookkeeping and win/lose.
// Optional enemy-phase watchdog is built when BATTLE_PHASE_TIMEOUT_EN is defined.
module battle_phase_ctrl #(
    parameter int unsigned PLAYER_HP      = 20,
    parameter int unsigned ENEMY_HP       = 30,
    parameter int unsigned HIT_DMG        = 4,
    parameter int unsigned NUM_TURNS      = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd650000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_in,
    input  logic       player_done_in,
    input  logic [7:0] player_dmg_in,
    input  logic       enemy_busy_in,
    input  logic       enemy_finished_in,
    input  logic       damage_in,
    output logic [3:0] state_out,
    output logic [3:0] turn_out,
    output logic [7:0] player_hp_out,
    output logic [7:0] enemy_hp_out,
    output logic       game_over_out,
    output logic       win_out,
    output logic       timeout_out
);
    localparam logic [7:0] PLAYER_HP_INIT = 8'(PLAYER_HP);
    localparam logic [7:0] ENEMY_HP_INIT  = 8'(ENEMY_HP);
    localparam logic [8:0] HIT_DMG_W      = 9'(HIT_DMG);
    localparam logic [3:0] TURN_LAST      = 4'(NUM_TURNS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b1010,
        S_PLAYER = 4'b0100,
        S_ENEMY  = 4'b1000,
        S_WIN    = 4'b0001,
        S_LOSE   = 4'b1111
    } state_e;

    state_e     state_q;
    logic [3:0] turn_q;
    logic [7:0] player_hp_q;
    logic [7:0] enemy_hp_q;
    logic       game_over_q;
    logic       win_q;

    logic [8:0] enemy_diff;
    logic [8:0] player_diff;
    logic [7:0] enemy_hp_d;
    logic [7:0] player_hp_d;
    logic [3:0] turn_d;
    logic       player_dead;

    // 9-bit subtraction; a set borrow bit means the true result went negative
    assign enemy_diff  = {1'b0, enemy_hp_q} - {1'b0, player_dmg_in};
    assign player_diff = {1'b0, player_hp_q} - HIT_DMG_W;
    assign enemy_hp_d  = enemy_diff[8] ? 8'd0 : enemy_diff[7:0];
    assign player_hp_d = player_diff[8] ? 8'd0 : player_diff[7:0];
    assign turn_d      = (turn_q == TURN_LAST) ? 4'd0 : turn_q + 4'd1;
    assign player_dead = damage_in && (player_hp_d == 8'd0);

`ifdef BATTLE_PHASE_TIMEOUT_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;
    logic        wd_expired;

    assign wd_expired  = (wd_cnt_q + 32'd1) == TIMEOUT_CYCLES;
    assign timeout_out = timeout_q;
    wire   unused_busy = enemy_busy_in;
`else
    assign timeout_out = 1'b0;
    wire [32:0] unused_cfg = {enemy_busy_in, TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            turn_q      <= 4'd0;
            player_hp_q <= PLAYER_HP_INIT;
            enemy_hp_q  <= ENEMY_HP_INIT;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
`ifdef BATTLE_PHASE_TIMEOUT_EN
            wd_cnt_q    <= 32'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_in) begin
                        state_q     <= S_PLAYER;
                        turn_q      <= 4'd0;
                        player_hp_q <= PLAYER_HP_INIT;
                        enemy_hp_q  <= ENEMY_HP_INIT;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                end
                S_PLAYER: begin
                    if (player_done_in) begin
                        enemy_hp_q <= enemy_hp_d;
                        if (enemy_hp_d == 8'd0) begin
                            state_q     <= S_WIN;
                            game_over_q <= 1'b1;
                            win_q       <= 1'b1;
                        end else begin
                            state_q <= S_ENEMY;
`ifdef BATTLE_PHASE_TIMEOUT_EN
                            wd_cnt_q <= 32'd0;
`endif
                        end
                    end
                end
                S_ENEMY: begin
                    // damage resolves before finish so a lethal hit never advances the turn
                    if (damage_in) begin
                        player_hp_q <= player_hp_d;
                    end
                    if (player_dead) begin
                        state_q     <= S_LOSE;
                        game_over_q <= 1'b1;
                    end else if (enemy_finished_in) begin
                        state_q <= S_PLAYER;
                        turn_q  <= turn_d;
                    end
`ifdef BATTLE_PHASE_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_q   <= S_PLAYER;
                        turn_q    <= turn_d;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_out     = state_q;
    assign turn_out      = turn_q;
    assign player_hp_out = player_hp_q;
    assign enemy_hp_out  = enemy_hp_q;
    assign game_over_out = game_over_q;
    assign win_out       = win_q;
endmodule
